// File: rtl/wgt_load_seq.sv
// Weight-layer sequencer: streams 16x16 signed weight bytes into the bank memories,
// then fires the layer start and waits for finish. Optional macro: WGT_LOAD_CKSUM_EN.
module wgt_load_seq #(
  parameter int NBANK = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             xrst,
  input  logic             load,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [DW-1:0]    cfg_data,
  output logic             cfg_ready,
  output logic [NBANK-1:0] w_we,
  output logic [AW-1:0]    w_waddr,
  output logic [DW-1:0]    w_wdata,
  output logic             layer_start,
  input  logic             layer_finish,
  output logic             busy,
  output logic             wvalid,
  output logic             done,
  output logic             cksum_err,
  output logic [2:0]       state_dbg
);

  // Handshake: a stream byte transfers on a rising edge where cfg_valid & cfg_ready;
  // cfg_ready depends only on state, never on cfg_valid.

  localparam int TOTAL = NBANK * DEPTH;
  localparam int BW    = $clog2(NBANK);
  localparam int CW    = $clog2(TOTAL) + 1;
  localparam logic [CW-1:0]    LAST_W = CW'(TOTAL - 1);
  localparam logic [NBANK-1:0] ONE    = NBANK'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          accept, wbyte, start_load, load_end, load_ok;

  assign accept     = (state == S_LOAD) && cfg_valid;
  assign wbyte      = accept && (cnt <= LAST_W);
  assign start_load = load && ((state == S_IDLE) || (state == S_READY));

`ifdef WGT_LOAD_CKSUM_EN
  logic [15:0]   sum;
  logic [DW-1:0] ck_lo;

  // Two trailing bytes carry the checksum, low byte first.
  assign load_end = accept && (cnt == CW'(TOTAL + 1));
  assign load_ok  = ({cfg_data, ck_lo} == sum);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      sum       <= '0;
      ck_lo     <= '0;
      cksum_err <= 1'b0;
    end else begin
      if (start_load) sum <= '0;
      else if (wbyte) sum <= sum + {{(16-DW){cfg_data[DW-1]}}, cfg_data};
      if (accept && (cnt == CW'(TOTAL))) ck_lo <= cfg_data;
      if (start_load) cksum_err <= 1'b0;
      else if (load_end && !load_ok) cksum_err <= 1'b1;
    end
  end
`else
  assign load_end  = accept && (cnt == LAST_W);
  assign load_ok   = 1'b1;
  assign cksum_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (load) state_nx = S_LOAD;
      S_LOAD:  if (load_end) state_nx = load_ok ? S_READY : S_IDLE;
      S_READY: begin
        if (load)     state_nx = S_LOAD;
        else if (run) state_nx = S_START;
      end
      S_START: state_nx = S_WAIT;
      S_WAIT:  if (layer_finish) state_nx = S_READY;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (start_load)  cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;
    end
  end

  // Byte k lands in bank k mod NBANK at row k / NBANK, one cycle after acceptance.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      w_we    <= '0;
      w_waddr <= '0;
      w_wdata <= '0;
      done    <= 1'b0;
    end else begin
      w_we <= wbyte ? (ONE << cnt[BW-1:0]) : '0;
      if (wbyte) begin
        w_waddr <= cnt[BW+AW-1:BW];
        w_wdata <= cfg_data;
      end
      done <= (state == S_WAIT) && layer_finish;
    end
  end

  assign cfg_ready   = (state == S_LOAD);
  assign layer_start = (state == S_START);
  assign busy        = (state == S_LOAD) || (state == S_START) || (state == S_WAIT);
  assign wvalid      = (state == S_READY) || (state == S_START) || (state == S_WAIT);
  assign state_dbg   = state;

endmodule

// File: tb/tb_wgt_load_seq.sv
// Bench for wgt_load_seq: random byte streams, expected bank writes queued by a
// reference model and popped by an independent write monitor.
module tb_wgt_load_seq;

  localparam int NB    = 16;
  localparam int TOTAL = 256;
  localparam int W     = 28;

  logic        clk = 1'b0;
  logic        xrst = 1'b0;
  logic        load = 1'b0, run = 1'b0, cfg_valid = 1'b0, layer_finish = 1'b0;
  logic [7:0]  cfg_data = '0;
  logic        cfg_ready, layer_start, busy, wvalid, done, cksum_err;
  logic [15:0] w_we;
  logic [3:0]  w_waddr;
  logic [7:0]  w_wdata;
  logic [2:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  wgt_load_seq dut (
    .clk(clk), .xrst(xrst), .load(load), .run(run),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .w_we(w_we), .w_waddr(w_waddr), .w_wdata(w_wdata),
    .layer_start(layer_start), .layer_finish(layer_finish),
    .busy(busy), .wvalid(wvalid), .done(done), .cksum_err(cksum_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- write monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (xrst && (w_we != '0)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got we=%h addr=%h data=%h expected no write",
                 w_we, w_waddr, w_wdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({w_we, w_waddr, w_wdata} !== e) begin
          errors++;
          $display("FAIL bank_write: got we=%h addr=%h data=%h expected we=%h addr=%h data=%h",
                   w_we, w_waddr, w_wdata, e[27:12], e[11:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("load_state", state_dbg, 3'd1);
    chk("load_ready", {cfg_ready, busy, wvalid}, 3'b110);
  endtask

  // mode 0: data=k, 1: random, 2: all 0xFF
  task automatic stream_bytes(input int n, input int mode, input int gap_pct, input bit bad_ck);
    logic [7:0]  d;
    logic [15:0] sum;
    sum = '0;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       d = 8'(k);
        1:       d = 8'($urandom_range(255));
        default: d = 8'hFF;
      endcase
      while ($urandom_range(99) < gap_pct) begin
        cfg_valid = 1'b0;
        tick();
      end
      cfg_valid = 1'b1;
      cfg_data  = d;
      exp_q.push_back({16'(1) << (k % NB), 4'(k / NB), d});
      sum = sum + {{8{d[7]}}, d};
      tick();
    end
`ifdef WGT_LOAD_CKSUM_EN
    if (n == TOTAL) begin
      cfg_valid = 1'b1;
      cfg_data  = sum[7:0] ^ {7'd0, bad_ck};
      tick();
      cfg_data  = sum[15:8];
      tick();
    end
`endif
    cfg_valid = 1'b0;
  endtask

  task automatic end_of_load(input bit bad_ck);
    chk("load_end_wvalid", wvalid, !bad_ck);
    chk("load_end_cfg_ready", cfg_ready, 1'b0);
    chk("load_end_state", state_dbg, bad_ck ? 3'd0 : 3'd2);
    chk("load_end_cksum_err", cksum_err, bad_ck);
  endtask

  task automatic do_run(input int delay);
    int seen;
    seen = 0;
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("run_layer_start", {layer_start, busy}, 2'b11);
    tick();
    chk("run_start_one_cycle", {layer_start, state_dbg}, {1'b0, 3'd4});
    for (int i = 0; i < delay; i++) begin
      if (done || layer_start) seen++;
      tick();
    end
    chk("wait_no_done", seen, 0);
    chk("wait_busy", busy, 1'b1);
    layer_finish = 1'b1;
    tick();
    layer_finish = 1'b0;
    chk("done_pulse", {done, busy, wvalid, state_dbg}, {3'b101, 3'd2});
    tick();
    chk("done_one_cycle", done, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick();
    tick();
    chk("reset_outputs", {w_we, w_waddr, w_wdata, cfg_ready, wvalid, cksum_err,
                          busy, layer_start, done, state_dbg}, '0);
    xrst = 1'b1;
    tick();

    // run without weights is ignored
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("idle_run_ignored", {layer_start, busy, wvalid, state_dbg}, '0);
    tick();
    chk("idle_run_no_start", {layer_start, state_dbg}, '0);

    // full-rate load with data = k
    pulse_load();
    stream_bytes(TOTAL, 0, 0, 1'b0);
    end_of_load(1'b0);

    // gapped random load aborted by reset
    pulse_load();
    stream_bytes(101, 1, 30, 1'b0);
    tick();
    chk("partial_writes_drained", exp_q.size(), 0);
    xrst = 1'b0;
    #1;
    chk("abort_outputs", {w_we, w_waddr, w_wdata, cfg_ready, wvalid, cksum_err,
                          busy, layer_start, done, state_dbg}, '0);
    exp_q.delete();
    tick();
    xrst = 1'b1;
    tick();

    pulse_load();
    stream_bytes(TOTAL, 1, 0, 1'b0);
    end_of_load(1'b0);

    do_run(50);
    do_run(3);

    // load wins over run; finish during LOAD is ignored
    load = 1'b1;
    run  = 1'b1;
    tick();
    load = 1'b0;
    run  = 1'b0;
    chk("load_wins", {layer_start, cfg_ready, state_dbg}, {2'b01, 3'd1});
    layer_finish = 1'b1;
    tick();
    layer_finish = 1'b0;
    chk("finish_in_load_ignored", {done, layer_start, state_dbg}, {2'b00, 3'd1});
    stream_bytes(TOTAL, 1, 25, 1'b0);
    end_of_load(1'b0);

    for (int r = 0; r < 4; r++) do_run($urandom_range(1, 12));

`ifdef WGT_LOAD_CKSUM_EN
    pulse_load();
    stream_bytes(TOTAL, 2, 0, 1'b0);
    end_of_load(1'b0);
    pulse_load();
    stream_bytes(TOTAL, 2, 10, 1'b1);
    end_of_load(1'b1);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("cksum_fail_run_ignored", {layer_start, busy}, 2'b00);
    pulse_load();
    chk("cksum_err_cleared", cksum_err, 1'b0);
    stream_bytes(TOTAL, 1, 20, 1'b0);
    end_of_load(1'b0);
    do_run(2);
`endif

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
